ghost_chaser: RTL and testbench

//  Generates the ghost's sprite position for the VGA display stage. Today

---
 rtl/ghost_chaser.sv | 203 ++++++++++++++++++++
 tb/tb_ghost_chaser.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghost_chaser.sv
// Ghost sprite position generator: steps one pixel per movement tick toward a
// mode-dependent target and flags collisions with Pac-Man.
//
//  mode     | meaning
//  SCATTER  | head for the home corner; times out into CHASE
//  CHASE    | head for Pac-Man; times out into SCATTER
//  FRIGHT   | flee Pac-Man; times out into CHASE, restarts on every pellet
//  RETURN   | eaten, run home at 2 px/step; SCATTER once back at INIT
module ghost_chaser #(
   parameter int STEP_DIV      = 1_000_000,
   parameter int X_MIN         = 0,
   parameter int X_MAX         = 620,
   parameter int Y_MIN         = 0,
   parameter int Y_MAX         = 460,
   parameter int INIT_X        = 250,
   parameter int INIT_Y        = 146,
   parameter int HOME_X        = 600,
   parameter int HOME_Y        = 20,
   parameter int SCATTER_STEPS = 400,
   parameter int CHASE_STEPS   = 1400,
   parameter int FRIGHT_STEPS  = 600,
   parameter int HIT_DIST      = 8
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       enable,
   input  logic       fright_req,
   input  logic [9:0] pac_x,
   input  logic [8:0] pac_y,
   output logic [9:0] ghost_x,
   output logic [8:0] ghost_y,
   output logic [1:0] mode,
   output logic       caught,
   output logic       eaten
);

   localparam int T_SC = (SCATTER_STEPS > CHASE_STEPS) ? SCATTER_STEPS : CHASE_STEPS;
   localparam int T_MAX = (T_SC > FRIGHT_STEPS) ? T_SC : FRIGHT_STEPS;
   localparam int TW = $clog2(T_MAX + 1);
   localparam int PW = $clog2(STEP_DIV + 1);
   localparam logic signed [11:0] X_LO = 12'(X_MIN);
   localparam logic signed [11:0] X_HI = 12'(X_MAX);
   localparam logic signed [11:0] Y_LO = 12'(Y_MIN);
   localparam logic signed [11:0] Y_HI = 12'(Y_MAX);

   typedef enum logic [1:0] {
      M_SCATTER = 2'd0,
      M_CHASE   = 2'd1,
      M_FRIGHT  = 2'd2,
      M_RETURN  = 2'd3
   } mode_t;

   mode_t             mode_q, mode_d;
   logic [PW-1:0]     pre_q, pre_d;
   logic [TW-1:0]     tmr_q, tmr_d, tmr_last;
   logic [9:0]        x_d, mv_x, tgt_x;
   logic [8:0]        y_d, mv_y, tgt_y;
   logic              caught_d, eaten_d;
   logic signed [10:0] dx, pdx;
   logic signed [9:0]  dy, pdy;
   logic [10:0]       mag_x, pmag_x;
   logic [9:0]        mag_y, pmag_y;
   logic signed [11:0] gx_s, gy_s, amt_x, amt_y, cand_x, cand_y;
   logic              step, hit, at_init, flip, ret;
   logic              neg_x, neg_y, ok_x, ok_y, x_first, moving;

   assign mode = mode_q;
   assign step = enable && (pre_q == PW'(STEP_DIV - 1));
   assign flip = (mode_q == M_FRIGHT);
   assign ret  = (mode_q == M_RETURN);
   assign at_init = (ghost_x == 10'(INIT_X)) && (ghost_y == 9'(INIT_Y));

   // FRIGHT aims at Pac-Man too; the move direction is inverted below
   always_comb begin
      tgt_x = 10'(HOME_X);
      tgt_y = 9'(HOME_Y);
      case (mode_q)
         M_CHASE, M_FRIGHT: begin
            tgt_x = pac_x;
            tgt_y = pac_y;
         end
         M_RETURN: begin
            tgt_x = 10'(INIT_X);
            tgt_y = 9'(INIT_Y);
         end
         default: ;
      endcase
   end

   assign dx     = $signed({1'b0, tgt_x}) - $signed({1'b0, ghost_x});
   assign dy     = $signed({1'b0, tgt_y}) - $signed({1'b0, ghost_y});
   assign pdx    = $signed({1'b0, pac_x}) - $signed({1'b0, ghost_x});
   assign pdy    = $signed({1'b0, pac_y}) - $signed({1'b0, ghost_y});
   assign mag_x  = $unsigned(dx[10] ? -dx : dx);
   assign mag_y  = $unsigned(dy[9] ? -dy : dy);
   assign pmag_x = $unsigned(pdx[10] ? -pdx : pdx);
   assign pmag_y = $unsigned(pdy[9] ? -pdy : pdy);

   assign hit = enable && !ret && (pmag_x < 11'(HIT_DIST)) && (pmag_y < 10'(HIT_DIST));

   assign gx_s  = $signed({2'b00, ghost_x});
   assign gy_s  = $signed({3'b000, ghost_y});
   assign amt_x = (ret && mag_x > 11'd1) ? 12'sd2 : 12'sd1;
   assign amt_y = (ret && mag_y > 10'd1) ? 12'sd2 : 12'sd1;
   // fleeing on an axis with zero delta goes toward the positive side
   assign neg_x = flip ? (!dx[10] && dx != 11'sd0) : dx[10];
   assign neg_y = flip ? (!dy[9] && dy != 10'sd0) : dy[9];
   assign cand_x = neg_x ? gx_s - amt_x : gx_s + amt_x;
   assign cand_y = neg_y ? gy_s - amt_y : gy_s + amt_y;
   assign ok_x = (flip || dx != 11'sd0) && (cand_x >= X_LO) && (cand_x <= X_HI);
   assign ok_y = (flip || dy != 10'sd0) && (cand_y >= Y_LO) && (cand_y <= Y_HI);
   assign x_first = (mag_x >= {1'b0, mag_y});
   assign moving  = (dx != 11'sd0) || (dy != 10'sd0);

   always_comb begin
      mv_x = ghost_x;
      mv_y = ghost_y;
      if (moving) begin
         if (x_first) begin
            if (ok_x)      mv_x = cand_x[9:0];
            else if (ok_y) mv_y = cand_y[8:0];
         end else begin
            if (ok_y)      mv_y = cand_y[8:0];
            else if (ok_x) mv_x = cand_x[9:0];
         end
      end
   end

   always_comb begin
      case (mode_q)
         M_SCATTER: tmr_last = TW'(SCATTER_STEPS - 1);
         M_CHASE:   tmr_last = TW'(CHASE_STEPS - 1);
         default:   tmr_last = TW'(FRIGHT_STEPS - 1);
      endcase
   end

   always_comb begin
      mode_d   = mode_q;
      tmr_d    = tmr_q;
      pre_d    = pre_q;
      x_d      = ghost_x;
      y_d      = ghost_y;
      caught_d = 1'b0;
      eaten_d  = 1'b0;
      if (enable) begin
         pre_d = step ? '0 : pre_q + PW'(1);
         if (hit) begin
            tmr_d = '0;
            if (mode_q == M_FRIGHT) begin
               eaten_d = 1'b1;
               mode_d  = M_RETURN;
            end else begin
               caught_d = 1'b1;
               mode_d   = M_SCATTER;
               x_d      = 10'(INIT_X);
               y_d      = 9'(INIT_Y);
            end
         end else begin
            if (step) begin
               x_d = mv_x;
               y_d = mv_y;
            end
            if (ret) begin
               if (at_init) begin
                  mode_d = M_SCATTER;
                  tmr_d  = '0;
               end
            end else if (fright_req) begin
               mode_d = M_FRIGHT;
               tmr_d  = '0;
            end else if (step) begin
               if (tmr_q == tmr_last) begin
                  tmr_d  = '0;
                  mode_d = (mode_q == M_CHASE) ? M_SCATTER : M_CHASE;
               end else begin
                  tmr_d = tmr_q + TW'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         mode_q  <= M_SCATTER;
         tmr_q   <= '0;
         pre_q   <= '0;
         ghost_x <= 10'(INIT_X);
         ghost_y <= 9'(INIT_Y);
         caught  <= 1'b0;
         eaten   <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         tmr_q   <= tmr_d;
         pre_q   <= pre_d;
         ghost_x <= x_d;
         ghost_y <= y_d;
         caught  <= caught_d;
         eaten   <= eaten_d;
      end
   end

endmodule

// File: tb/tb_ghost_chaser.sv
// Bench for ghost_chaser: directed game scenarios plus a randomized run, all
// checked against a cycle-level behavioural model of the ghost rules.
module tb_ghost_chaser;

   localparam int SD = 4, SS = 8, CS = 16, FS = 6;

   logic       clk = 1'b0;
   logic       clrn, enable, fright_req;
   logic [9:0] pac_x;
   logic [8:0] pac_y;
   logic [9:0] ghost_x;
   logic [8:0] ghost_y;
   logic [1:0] mode;
   logic       caught, eaten;

   int n_err = 0, n_chk = 0;
   int m_x, m_y, m_mode, m_left, m_pre;
   bit m_caught, m_eaten;

   ghost_chaser #(.STEP_DIV(SD), .SCATTER_STEPS(SS), .CHASE_STEPS(CS), .FRIGHT_STEPS(FS)) dut (
      .clk(clk), .clrn(clrn), .enable(enable), .fright_req(fright_req),
      .pac_x(pac_x), .pac_y(pac_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
      .mode(mode), .caught(caught), .eaten(eaten));

   always #5 clk = ~clk;

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic model_reset();
      m_x = 250; m_y = 146; m_mode = 0; m_left = SS; m_pre = 0;
      m_caught = 0; m_eaten = 0;
   endtask

   // one step: try the larger-delta axis, then the other; first legal move wins
   task automatic model_move();
      int p[2], d[2], lim[2];
      int first, a, s, amt, np;
      p[0] = m_x; p[1] = m_y; lim[0] = 620; lim[1] = 460;
      case (m_mode)
         0: begin d[0] = 600 - m_x; d[1] = 20 - m_y; end
         3: begin d[0] = 250 - m_x; d[1] = 146 - m_y; end
         default: begin d[0] = int'(pac_x) - m_x; d[1] = int'(pac_y) - m_y; end
      endcase
      if (d[0] == 0 && d[1] == 0) return;
      first = (iabs(d[0]) >= iabs(d[1])) ? 0 : 1;
      for (int k = 0; k < 2; k++) begin
         a = (k == 0) ? first : 1 - first;
         if (m_mode != 2 && d[a] == 0) continue;
         if (m_mode == 2) s = (d[a] > 0) ? -1 : 1;
         else             s = (d[a] > 0) ? 1 : -1;
         amt = (m_mode == 3 && iabs(d[a]) >= 2) ? 2 : 1;
         np = p[a] + s * amt;
         if (np >= 0 && np <= lim[a]) begin
            p[a] = np;
            m_x = p[0]; m_y = p[1];
            return;
         end
      end
   endtask

   task automatic model_tick();
      bit st, hit, home;
      m_caught = 0; m_eaten = 0;
      if (!enable) return;
      st = (m_pre == SD - 1);
      m_pre = st ? 0 : m_pre + 1;
      hit = (m_mode != 3) && iabs(int'(pac_x) - m_x) < 8 && iabs(int'(pac_y) - m_y) < 8;
      if (hit) begin
         if (m_mode == 2) begin
            m_eaten = 1; m_mode = 3;
         end else begin
            m_caught = 1; m_x = 250; m_y = 146; m_mode = 0; m_left = SS;
         end
         return;
      end
      home = (m_x == 250 && m_y == 146);
      if (st) model_move();
      if (m_mode == 3) begin
         if (home) begin m_mode = 0; m_left = SS; end
      end else if (fright_req) begin
         m_mode = 2; m_left = FS;
      end else if (st) begin
         m_left--;
         if (m_left == 0) begin
            if (m_mode == 1) begin m_mode = 0; m_left = SS; end
            else             begin m_mode = 1; m_left = CS; end
         end
      end
   endtask

   always @(posedge clk or negedge clrn) begin
      if (!clrn) model_reset();
      else       model_tick();
   end

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      #3 clrn = 1'b0;
      @(negedge clk);
      n_chk++;
      if (ghost_x !== 10'd250 || ghost_y !== 9'd146) begin
         n_err++; $display("FAIL reset_pos: got (%0d,%0d) want (250,146)", ghost_x, ghost_y);
      end
      n_chk++;
      if (mode !== 2'd0 || caught !== 1'b0 || eaten !== 1'b0) begin
         n_err++; $display("FAIL reset_flags: got mode=%0d c=%0b e=%0b want 0 0 0", mode, caught, eaten);
      end
      @(negedge clk);
      clrn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_scatter_chase();
      enable = 1'b1;
      run(3);
      n_chk++;
      if (ghost_x !== 10'd250) begin
         n_err++; $display("FAIL early_move: got x=%0d want 250", ghost_x);
      end
      run(1);
      n_chk++;
      if (ghost_x !== 10'd251 || ghost_y !== 9'd146) begin
         n_err++; $display("FAIL first_step: got (%0d,%0d) want (251,146)", ghost_x, ghost_y);
      end
      run(28);
      n_chk++;
      if (mode !== 2'd1 || ghost_x !== 10'd258 || ghost_y !== 9'd146) begin
         n_err++; $display("FAIL to_chase: got mode=%0d (%0d,%0d) want 1 (258,146)", mode, ghost_x, ghost_y);
      end
      run(20);
      n_chk++;
      if (mode !== 2'd1 || ghost_x !== 10'd258 || ghost_y !== 9'd151) begin
         n_err++; $display("FAIL chase_y: got mode=%0d (%0d,%0d) want 1 (258,151)", mode, ghost_x, ghost_y);
      end
   endtask

   task automatic test_caught();
      pac_x = 10'd263; pac_y = 9'd151;
      @(negedge clk);
      n_chk++;
      if (caught !== 1'b1 || ghost_x !== 10'd250 || ghost_y !== 9'd146 || mode !== 2'd0) begin
         n_err++; $display("FAIL caught: got c=%0b (%0d,%0d) mode=%0d want 1 (250,146) 0", caught, ghost_x, ghost_y, mode);
      end
      @(negedge clk);
      n_chk++;
      if (caught !== 1'b0 || ghost_x !== 10'(m_x) || mode !== 2'd0) begin
         n_err++; $display("FAIL caught_pulse: got c=%0b x=%0d mode=%0d want 0 %0d 0", caught, ghost_x, mode, m_x);
      end
   endtask

   task automatic test_fright();
      int i, x0;
      pac_x = 10'd600; pac_y = 9'd400;
      i = 0;
      while (mode !== 2'd1 && i < 100) begin @(negedge clk); i++; end
      n_chk++;
      if (mode !== 2'd1) begin
         n_err++; $display("FAIL wait_chase: got mode=%0d want 1", mode);
      end
      pac_x = 10'd200; pac_y = 9'd146; fright_req = 1'b1;
      @(negedge clk);
      fright_req = 1'b0;
      n_chk++;
      if (mode !== 2'd2) begin
         n_err++; $display("FAIL fright_enter: got mode=%0d want 2", mode);
      end
      x0 = int'(ghost_x);
      run(12);
      n_chk++;
      if (int'(ghost_x) <= x0 || ghost_x !== 10'(m_x) || ghost_y !== 9'(m_y)) begin
         n_err++; $display("FAIL fright_flee: got (%0d,%0d) want (%0d,%0d) x>%0d", ghost_x, ghost_y, m_x, m_y, x0);
      end
      fright_req = 1'b1;
      @(negedge clk);
      fright_req = 1'b0;
      run(19);
      n_chk++;
      if (mode !== 2'd2) begin
         n_err++; $display("FAIL fright_extend: got mode=%0d want 2", mode);
      end
      run(5);
      n_chk++;
      if (mode !== 2'd1) begin
         n_err++; $display("FAIL fright_expire: got mode=%0d want 1", mode);
      end
   endtask

   task automatic test_eaten();
      int i, xr;
      fright_req = 1'b1;
      @(negedge clk);
      fright_req = 1'b0;
      pac_x = 10'(m_x + 3); pac_y = 9'(m_y);
      @(negedge clk);
      n_chk++;
      if (eaten !== 1'b1 || mode !== 2'd3) begin
         n_err++; $display("FAIL eaten: got e=%0b mode=%0d want 1 3", eaten, mode);
      end
      pac_x = 10'd600; pac_y = 9'd400; fright_req = 1'b1;
      @(negedge clk);
      fright_req = 1'b0;
      n_chk++;
      if (eaten !== 1'b0 || mode !== 2'd3) begin
         n_err++; $display("FAIL return_ignores_fright: got e=%0b mode=%0d want 0 3", eaten, mode);
      end
      xr = int'(ghost_x);
      i = 0;
      while (int'(ghost_x) == xr && i < 8) begin @(negedge clk); i++; end
      n_chk++;
      if (xr - int'(ghost_x) != 2) begin
         n_err++; $display("FAIL return_speed: got x %0d->%0d want step of 2", xr, ghost_x);
      end
      i = 0;
      while (mode !== 2'd0 && i < 200) begin @(negedge clk); i++; end
      n_chk++;
      if (mode !== 2'd0 || ghost_x !== 10'd250 || ghost_y !== 9'd146) begin
         n_err++; $display("FAIL return_home: got mode=%0d (%0d,%0d) want 0 (250,146)", mode, ghost_x, ghost_y);
      end
   endtask

   task automatic test_bounds();
      int i, ya, over;
      logic [9:0] sx; logic [8:0] sy; logic [1:0] sm; bit pulse;
      over = 0; i = 0;
      while (m_x != 620 && i < 3000) begin
         pac_x = 10'(m_x - 50); pac_y = 9'(m_y); fright_req = (i % 16 == 0);
         @(negedge clk);
         if (ghost_x > 10'd620) over++;
         i++;
      end
      n_chk++;
      if (ghost_x !== 10'd620 || ghost_y !== 9'(m_y)) begin
         n_err++; $display("FAIL reach_xmax: got (%0d,%0d) want (620,%0d)", ghost_x, ghost_y, m_y);
      end
      ya = int'(ghost_y);
      for (int k = 0; k < 40; k++) begin
         pac_x = 10'(m_x - 50); pac_y = 9'(m_y); fright_req = (k % 16 == 0);
         @(negedge clk);
         if (ghost_x > 10'd620) over++;
      end
      fright_req = 1'b0;
      n_chk++;
      if (over != 0 || ghost_x !== 10'd620 || int'(ghost_y) == ya || mode !== 2'd2) begin
         n_err++; $display("FAIL xmax_fallback: got x=%0d y=%0d (was %0d) mode=%0d over=%0d want x=620 y moved mode=2",
                           ghost_x, ghost_y, ya, mode, over);
      end
      sx = ghost_x; sy = ghost_y; sm = mode; pulse = 0;
      enable = 1'b0; pac_x = ghost_x; pac_y = ghost_y;
      for (int k = 0; k < 20; k++) begin
         fright_req = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (caught || eaten) pulse = 1;
      end
      fright_req = 1'b0;
      n_chk++;
      if (ghost_x !== sx || ghost_y !== sy || mode !== sm || pulse) begin
         n_err++; $display("FAIL freeze: got (%0d,%0d) mode=%0d pulse=%0b want (%0d,%0d) mode=%0d pulse=0",
                           ghost_x, ghost_y, mode, pulse, sx, sy, sm);
      end
      pac_x = 10'd570; pac_y = 9'd400; enable = 1'b1; fright_req = 1'b1;
      @(negedge clk);
      fright_req = 1'b0;
      run(6);
      #2 clrn = 1'b0;
      #1;
      n_chk++;
      if (ghost_x !== 10'd250 || ghost_y !== 9'd146 || mode !== 2'd0 || caught || eaten) begin
         n_err++; $display("FAIL async_reset: got (%0d,%0d) mode=%0d c=%0b e=%0b want (250,146) 0 0 0",
                           ghost_x, ghost_y, mode, caught, eaten);
      end
      @(negedge clk);
      clrn = 1'b1;
   endtask

   task automatic test_random();
      int r, v, bad;
      bad = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         n_chk++;
         if (ghost_x !== 10'(m_x) || ghost_y !== 9'(m_y) || mode !== 2'(m_mode) ||
             caught !== m_caught || eaten !== m_eaten) begin
            n_err++;
            if (bad < 10)
               $display("FAIL random cyc %0d: got (%0d,%0d) mode=%0d c=%0b e=%0b want (%0d,%0d) mode=%0d c=%0b e=%0b",
                        c, ghost_x, ghost_y, mode, caught, eaten, m_x, m_y, m_mode, m_caught, m_eaten);
            bad++;
         end
         enable     = ($urandom_range(0, 19) != 0);
         fright_req = ($urandom_range(0, 59) == 0);
         r = $urandom_range(0, 99);
         if (r < 4) begin
            v = m_x + $urandom_range(0, 20) - 10; pac_x = 10'((v < 0) ? 0 : v);
            v = m_y + $urandom_range(0, 20) - 10; pac_y = 9'((v < 0) ? 0 : v);
         end else if (r < 6) begin
            pac_x = 10'($urandom_range(0, 1023));
            pac_y = 9'($urandom_range(0, 511));
         end
      end
   endtask

   initial begin
      clrn = 1'b1; enable = 1'b0; fright_req = 1'b0;
      pac_x = 10'd250; pac_y = 9'd300;
      test_reset();
      test_scatter_chase();
      test_caught();
      test_fright();
      test_eaten();
      test_bounds();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
